// File: rtl/muls_pkg.sv
// muls_pkg: shared definitions for the sequential Booth multiplier.
//   - state_e   : controller states (IDLE / BUSY / DONE)
//   - OP_*      : radix-2 Booth opcodes, encoded as {q0, q-1}
//   - cnt_width : width of the iteration counter, clog2(WIDTH+2),
//                 wide enough to hold WIDTH+1
package muls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth opcodes, matching the {q0, q-1} bit pair that selects them.
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/muls_booth_step.sv
// muls_booth_step: one combinational radix-2 Booth iteration.
// Examines {lo[0], qm1}, adds/subtracts/ignores the multiplicand on the
// high half, then shifts {high, low, q-1} right arithmetically by one.
// Ports:
//   hi, lo, qm1     current accumulator (high half, low half, Booth bit q-1)
//   mcand           extended multiplicand (WIDTH+1 bits)
//   hi_next, lo_next, qm1_next   accumulator after the step
module muls_booth_step
    import muls_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] hi,
    input  logic [WIDTH:0] lo,
    input  logic           qm1,
    input  logic [WIDTH:0] mcand,
    output logic [WIDTH:0] hi_next,
    output logic [WIDTH:0] lo_next,
    output logic           qm1_next
);

    logic [1:0]       op;
    logic [WIDTH+1:0] hi_x;
    logic [WIDTH+1:0] mc_x;
    logic [WIDTH+1:0] sum;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path
        // can leave one unassigned and infer a latch.
        op   = {lo[0], qm1};
        // One guard bit keeps the add/sub exact; the shift drops it again.
        hi_x = {hi[WIDTH], hi};
        mc_x = {mcand[WIDTH], mcand};
        sum  = hi_x;
        case (op)
            OP_ADD:  sum = hi_x + mc_x;
            OP_SUB:  sum = hi_x - mc_x;
            OP_NOP:  sum = hi_x;
            default: sum = hi_x;      // 2'b11: also no add
        endcase
        hi_next  = sum[WIDTH+1:1];
        lo_next  = {sum[0], lo[WIDTH:1]};
        qm1_next = lo[0];
    end

endmodule

// File: rtl/muls_seq.sv
// muls_seq: iterative radix-2 Booth multiplier, signed or unsigned,
// with valid/ready handshakes on operands and product.
// One transaction in flight: accept in IDLE, WIDTH+1 Booth steps in BUSY,
// hold the product in DONE until the consumer takes it.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, in_signed sampled on accept)
//   in_signed            1 = two's-complement operands, 0 = unsigned
//   a, b                 multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready  product handshake
//   y                    product (PW = 2*WIDTH bits), held until next product
//   busy                 iteration in progress
// Build option: define MULS_ZERO_SKIP_EN to short-cut zero operands to a
// single step (latency 1); results are identical either way.
module muls_seq
    import muls_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    y,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state;
    logic [WIDTH:0] mcand;
    logic [WIDTH:0] hi;
    logic [WIDTH:0] lo;
    logic           qm1;
    logic [CW-1:0]  cnt;

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] hi_next;
    logic [WIDTH:0] lo_next;
    logic           qm1_next;

    assign a_ext = {in_signed & a[WIDTH-1], a};
    assign b_ext = {in_signed & b[WIDTH-1], b};

    // Handshake outputs decode straight from state so reset clears them
    // asynchronously.
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_BUSY);
    assign out_valid = (state == ST_DONE);

    muls_booth_step #(.WIDTH(WIDTH)) u_step (
        .hi       (hi),
        .lo       (lo),
        .qm1      (qm1),
        .mcand    (mcand),
        .hi_next  (hi_next),
        .lo_next  (lo_next),
        .qm1_next (qm1_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand <= a_ext;
                        hi    <= '0;
                        lo    <= b_ext;
                        qm1   <= 1'b0;
                        cnt   <= CW'(WIDTH + 1);
                        state <= ST_BUSY;
`ifdef MULS_ZERO_SKIP_EN
                        // A zero operand collapses the run to one NOP step
                        // on a cleared accumulator, producing y = 0.
                        if (a == '0 || b == '0) begin
                            mcand <= '0;
                            lo    <= '0;
                            cnt   <= CW'(1);
                        end
`endif
                    end
                end
                ST_BUSY: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    qm1 <= qm1_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Low PW bits of the 2*WIDTH+2-bit accumulator.
                        y     <= {hi_next[WIDTH-2:0], lo_next};
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muls_seq.sv
// tb_muls_seq: self-checking bench for muls_seq (WIDTH = 16).
// Expected products come from plain integer multiplication of the
// sign/zero-extended operands, truncated to 32 bits.
module tb_muls_seq;

    localparam int WIDTH = 16;
    localparam int PW    = 2 * WIDTH;
    localparam int LAT   = WIDTH + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_signed = 1'b0;
    logic [15:0]   a = '0;
    logic [15:0]   b = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [PW-1:0] y;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muls_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ref_mul(input logic [15:0] av, input logic [15:0] bv,
                                            input logic sv);
        longint ea, eb, p;
        ea = sv ? longint'(signed'(av)) : longint'(av);
        eb = sv ? longint'(signed'(bv)) : longint'(bv);
        p  = ea * eb;
        return p[31:0];
    endfunction

    function automatic int exp_lat(input logic [15:0] av, input logic [15:0] bv);
`ifdef MULS_ZERO_SKIP_EN
        if (av == 16'd0 || bv == 16'd0) return 1;
`endif
        return LAT;
    endfunction

    // Issue one operand pair, then scramble the inputs and count edges
    // until out_valid (lat = edges after the acceptance edge).
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic rdy, output int lat, output logic [31:0] yo);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        a = av; b = bv; in_signed = sv; in_valid = 1'b1; out_ready = rdy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); in_signed = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        yo = y;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests_run++; if (y !== 32'h0) begin tests_failed++; $display("FAIL reset_y: got %h want 0", y); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] yo;
        do_op(16'hFFE7, 16'd25, 1'b1, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'hFFFFFD8F) begin tests_failed++; $display("FAIL signed_m25x25: got %h want FFFFFD8F", yo); end
        tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL latency_m25x25: got %0d want %0d", lat, LAT); end
        @(posedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_pulse: out_valid=%0b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_after_done: in_ready=%0b want 1", in_ready); end
        do_op(16'd1001, 16'd831, 1'b1, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'd831831) begin tests_failed++; $display("FAIL signed_1001x831: got %0d want 831831", yo); end
        do_op(16'h8000, 16'h8000, 1'b1, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'h40000000) begin tests_failed++; $display("FAIL signed_minxmin: got %h want 40000000", yo); end
    endtask

    task automatic test_unsigned();
        int lat;
        logic [31:0] yo;
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'hFFFE0001) begin tests_failed++; $display("FAIL unsigned_max: got %h want FFFE0001", yo); end
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'h1) begin tests_failed++; $display("FAIL signed_m1xm1: got %h want 1", yo); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] yo;
        do_op(16'd300, 16'hFFF6, 1'b1, 1'b0, lat, yo);
        tests_run++; if (yo !== 32'hFFFFF448) begin tests_failed++; $display("FAIL bp_product: got %h want FFFFF448", yo); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            #1;
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_%0d: got %0b want 1", i, out_valid); end
            tests_run++; if (y !== 32'hFFFFF448) begin tests_failed++; $display("FAIL bp_y_%0d: got %h want FFFFF448", i, y); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_%0d: got %0b want 0", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        tests_run++; if (y !== 32'hFFFFF448) begin tests_failed++; $display("FAIL bp_y_hold: got %h want FFFFF448", y); end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [31:0] yo;
        @(negedge clk);
        a = 16'hFFEF; b = 16'd13; in_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before: got %0b want 1", busy); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %0b want 0", busy); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_in_ready: got %0b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_out_valid: got %0b want 0", out_valid); end
        tests_run++; if (y !== 32'h0) begin tests_failed++; $display("FAIL abort_y: got %h want 0", y); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'd17, 16'd13, 1'b1, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'd221) begin tests_failed++; $display("FAIL after_abort_y: got %0d want 221", yo); end
        tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL after_abort_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_zero();
        int lat;
        logic [31:0] yo;
        do_op(16'd0, 16'hFFFB, 1'b1, 1'b1, lat, yo);
        tests_run++; if (yo !== 32'h0) begin tests_failed++; $display("FAIL zero_y: got %h want 0", yo); end
        tests_run++; if (lat !== exp_lat(16'd0, 16'hFFFB)) begin tests_failed++; $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat(16'd0, 16'hFFFB)); end
    endtask

    task automatic test_back_to_back();
        int rises[$];
        logic prev;
        logic [31:0] exp;
        exp = ref_mul(16'd1234, 16'd4321, 1'b0);
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        a = 16'd1234; b = 16'd4321; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && !prev) rises.push_back(c);
            prev = out_valid;
        end
        in_valid = 1'b0;
        tests_run++;
        if (rises.size() < 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d products want at least 2", rises.size());
        end else if (rises[1] - rises[0] !== WIDTH + 3) begin
            tests_failed++;
            $display("FAIL b2b_interval: got %0d cycles want %0d", rises[1] - rises[0], WIDTH + 3);
        end
        tests_run++; if (y !== exp) begin tests_failed++; $display("FAIL b2b_y: got %h want %h", y, exp); end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] yo;
        logic [15:0] av, bv;
        logic sv;
        for (int i = 0; i < 40; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            sv = 1'($urandom_range(0, 1));
            if (i % 10 == 3) av = 16'd0;
            if (i % 10 == 7) bv = 16'd0;
            do_op(av, bv, sv, 1'b1, lat, yo);
            tests_run++;
            if (yo !== ref_mul(av, bv, sv)) begin
                tests_failed++;
                $display("FAIL rand_y_%0d: a=%h b=%h s=%0b got %h want %h", i, av, bv, sv, yo, ref_mul(av, bv, sv));
            end
            tests_run++;
            if (lat !== exp_lat(av, bv)) begin
                tests_failed++;
                $display("FAIL rand_latency_%0d: got %0d want %0d", i, lat, exp_lat(av, bv));
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_backpressure();
        test_reset_abort();
        test_zero();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
